// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and constants for the Simon round sequencer
package simon_pkg;

  // Width of the PASS/FAIL hold timer.
  localparam int HOLD_W = 8;

  // Score that ends a game in WIN unless the top level overrides it.
  localparam logic [3:0] WIN_SCORE_DEF = 4'd9;

  // Encoding is visible to the display mux, so the values are fixed.
  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_PLAY  = 3'd1,
    ST_FAIL  = 3'd2,
    ST_PASS  = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOAD  = 3'd5
  } state_t;

  // Score increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/simon_round_ctrl_if.sv
// rtl/simon_round_ctrl_if.sv - key-scanner/datapath signals seen by the round sequencer
interface simon_round_ctrl_if;

  // Inputs to the sequencer
  logic       sk_strobe;
  logic       simon_says;
  logic       combo_held;
  logic       stray_press;
  logic       any_held;
  logic       sd_is_empty;

  // Outputs of the sequencer
  logic       sd_srst;
  logic       fr_en;
  logic       mem_en;
  logic [3:0] score;
  logic [2:0] state;
  logic       is_correct;
  logic       is_wrong;
  logic [1:0] lives;

  // Sequencer side
  modport master (
    input  sk_strobe, simon_says, combo_held, stray_press, any_held, sd_is_empty,
    output sd_srst, fr_en, mem_en, score, state, is_correct, is_wrong, lives
  );

  // Key scanner / datapath side
  modport slave (
    output sk_strobe, simon_says, combo_held, stray_press, any_held, sd_is_empty,
    input  sd_srst, fr_en, mem_en, score, state, is_correct, is_wrong, lives
  );

endinterface

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - load/decrement dwell counter shared by PASS and FAIL
module hold_timer
  import simon_pkg::*;
#(
  parameter int HOLD_CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  // Loading HOLD_CYCLES-1 makes done rise in the HOLD_CYCLES-th cycle after load.
  localparam logic [HOLD_W-1:0] LOAD_VAL = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  // Next count: reload on entry, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/simon_round_ctrl.sv
// rtl/simon_round_ctrl.sv - Simon Says round sequencer; SIMON_LIVES_EN enables multi-life games
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter logic [3:0] WIN_SCORE   = WIN_SCORE_DEF,
  parameter int         HOLD_CYCLES = 100,
  parameter int         LIVES       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  simon_round_ctrl_if.master bus
);

  localparam logic [1:0] LIVES_RELOAD = 2'(LIVES);

  state_t     state_q, state_d;
  logic [3:0] score_q, score_d;
  logic       sd_srst_q, sd_srst_d;
  logic       fr_en_q, fr_en_d;
  logic       mem_en_q, mem_en_d;
  logic       is_correct_q, is_correct_d;
  logic       is_wrong_q, is_wrong_d;
  logic       timer_load;
  logic       hold_done;
  logic       verdict_pass;
  logic       verdict_fail;
`ifdef SIMON_LIVES_EN
  logic [1:0] lives_q, lives_d;
`endif

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .done (hold_done)
  );

  // PLAY verdict for this cycle; the first matching rule wins.
  always_comb begin
    verdict_pass = 1'b0;
    verdict_fail = 1'b0;
    if (bus.simon_says) begin
      if (bus.stray_press) begin
        verdict_fail = 1'b1;
      end else if (bus.combo_held) begin
        verdict_pass = 1'b1;
      end else if (bus.sd_is_empty) begin
        verdict_fail = 1'b1;
      end
    end else begin
      if (bus.sk_strobe) begin
        verdict_fail = 1'b1;
      end else if (bus.sd_is_empty) begin
        verdict_pass = 1'b1;
      end
    end
  end

  // Next state, score, lives and hold-timer reload.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    timer_load = 1'b0;
`ifdef SIMON_LIVES_EN
    lives_d    = lives_q;
`endif
    case (state_q)
      ST_READY: begin
        if (bus.sk_strobe) begin
          state_d = ST_LOAD;
          score_d = 4'd0;
`ifdef SIMON_LIVES_EN
          lives_d = LIVES_RELOAD;
`endif
        end
      end
      ST_LOAD: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (verdict_pass) begin
          state_d    = ST_PASS;
          score_d    = sat_inc4(score_q);
          timer_load = 1'b1;
        end else if (verdict_fail) begin
          state_d    = ST_FAIL;
          timer_load = 1'b1;
`ifdef SIMON_LIVES_EN
          lives_d    = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
`endif
        end
      end
      ST_PASS: begin
        if (hold_done && !bus.any_held) begin
          state_d = (score_q == WIN_SCORE) ? ST_WIN : ST_LOAD;
        end
      end
      ST_FAIL: begin
        if (hold_done && !bus.any_held) begin
`ifdef SIMON_LIVES_EN
          state_d = (lives_q != 2'd0) ? ST_LOAD : ST_READY;
`else
          state_d = ST_READY;
`endif
        end
      end
      ST_WIN: begin
        if (bus.sk_strobe) begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Indicator outputs decoded from the next state so they register alongside it.
  always_comb begin
    sd_srst_d    = (state_d != ST_PLAY);
    fr_en_d      = (state_d == ST_READY);
    mem_en_d     = (state_d == ST_LOAD);
    is_correct_d = (state_d == ST_PASS);
    is_wrong_d   = (state_d == ST_FAIL);
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_READY;
      score_q      <= 4'd0;
      sd_srst_q    <= 1'b1;
      fr_en_q      <= 1'b1;
      mem_en_q     <= 1'b0;
      is_correct_q <= 1'b0;
      is_wrong_q   <= 1'b0;
`ifdef SIMON_LIVES_EN
      lives_q      <= LIVES_RELOAD;
`endif
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      sd_srst_q    <= sd_srst_d;
      fr_en_q      <= fr_en_d;
      mem_en_q     <= mem_en_d;
      is_correct_q <= is_correct_d;
      is_wrong_q   <= is_wrong_d;
`ifdef SIMON_LIVES_EN
      lives_q      <= lives_d;
`endif
    end
  end

  assign bus.state      = state_q;
  assign bus.score      = score_q;
  assign bus.sd_srst    = sd_srst_q;
  assign bus.fr_en      = fr_en_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.is_correct = is_correct_q;
  assign bus.is_wrong   = is_wrong_q;
`ifdef SIMON_LIVES_EN
  assign bus.lives      = lives_q;
`else
  // Single-life build: the count is tied off, the parameter only keeps the port list uniform.
  assign bus.lives      = LIVES_RELOAD & 2'b00;
`endif

endmodule

// File: tb/tb_simon_round_ctrl.sv
// tb/tb_simon_round_ctrl.sv - self-checking bench for simon_round_ctrl
module tb_simon_round_ctrl;

  localparam int H   = 100;
  localparam int WIN = 9;
  localparam int LV  = 3;
`ifdef SIMON_LIVES_EN
  localparam bit LIVES_ON = 1'b1;
`else
  localparam bit LIVES_ON = 1'b0;
`endif
  localparam int LV_INIT = LIVES_ON ? LV : 0;

  // Game phases by name
  localparam int READY = 0, PLAY = 1, FAIL = 2, PASS = 3, WINS = 4, LOAD = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  simon_round_ctrl_if bus();

  simon_round_ctrl #(
    .WIN_SCORE  (4'd9),
    .HOLD_CYCLES(H),
    .LIVES      (LV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int st;
    int sc;
    int dw;
    int lv;
  } mdl_t;

  mdl_t m;

  // Game rules as a plain step function: dwell counted upward from entry.
  function automatic mdl_t step(input mdl_t c, input logic stb, input logic ss,
                                input logic combo, input logic stray,
                                input logic held, input logic empty);
    mdl_t n = c;
    int verdict = 0;
    case (c.st)
      READY: if (stb) begin n.st = LOAD; n.sc = 0; n.lv = LV_INIT; end
      LOAD:  n.st = PLAY;
      PLAY: begin
        if (ss) verdict = stray ? 2 : (combo ? 1 : (empty ? 2 : 0));
        else    verdict = stb ? 2 : (empty ? 1 : 0);
        if (verdict == 1) begin
          n.st = PASS; n.sc = (c.sc < 15) ? c.sc + 1 : 15; n.dw = 1;
        end else if (verdict == 2) begin
          n.st = FAIL; n.dw = 1; n.lv = (c.lv > 0) ? c.lv - 1 : 0;
        end
      end
      PASS: if (c.dw >= H && !held) n.st = (c.sc == WIN) ? WINS : LOAD;
            else n.dw = c.dw + 1;
      FAIL: if (c.dw >= H && !held) n.st = (LIVES_ON && c.lv > 0) ? LOAD : READY;
            else n.dw = c.dw + 1;
      WINS: if (stb) n.st = READY;
      default: n.st = READY;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{st: READY, sc: 0, dw: 0, lv: LV_INIT};
    end else begin
      m <= step(m, bus.sk_strobe, bus.simon_says, bus.combo_held,
                bus.stray_press, bus.any_held, bus.sd_is_empty);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state",      int'(bus.state),      m.st);
      chk("m_score",      int'(bus.score),      m.sc);
      chk("m_sd_srst",    int'(bus.sd_srst),    int'(m.st != PLAY));
      chk("m_fr_en",      int'(bus.fr_en),      int'(m.st == READY));
      chk("m_mem_en",     int'(bus.mem_en),     int'(m.st == LOAD));
      chk("m_is_correct", int'(bus.is_correct), int'(m.st == PASS));
      chk("m_is_wrong",   int'(bus.is_wrong),   int'(m.st == FAIL));
      chk("m_lives",      int'(bus.lives),      m.lv);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.sk_strobe   = 1'b0;
    bus.combo_held  = 1'b0;
    bus.stray_press = 1'b0;
    bus.any_held    = 1'b0;
    bus.sd_is_empty = 1'b0;
  endtask

  // Steer the game into PLAY from wherever it is.
  task automatic go_play();
    for (int i = 0; i < 1000 && int'(bus.state) != PLAY; i++) begin
      idle_inputs();
      bus.sk_strobe = (int'(bus.state) == READY || int'(bus.state) == WINS);
      tick();
    end
    bus.sk_strobe = 1'b0;
    chk("go_play", int'(bus.state), PLAY);
  endtask

  task automatic wait_leave(input int s);
    int n = 0;
    idle_inputs();
    while (int'(bus.state) == s && n < 1000) begin
      n++;
      tick();
    end
    chk("leave_state", int'(int'(bus.state) != s), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.simon_says = 1'b0;
    idle_inputs();
    repeat (3) tick();
    chk_en = 1'b1;

    // Reset values
    chk("rst_state",      int'(bus.state), 0);
    chk("rst_score",      int'(bus.score), 0);
    chk("rst_sd_srst",    int'(bus.sd_srst), 1);
    chk("rst_fr_en",      int'(bus.fr_en), 1);
    chk("rst_mem_en",     int'(bus.mem_en), 0);
    chk("rst_is_correct", int'(bus.is_correct), 0);
    chk("rst_is_wrong",   int'(bus.is_wrong), 0);
    chk("rst_lives",      int'(bus.lives), LV_INIT);
    rst_n = 1'b1;
    tick();

    // Strobe: READY -> LOAD (1 cycle) -> PLAY
    bus.sk_strobe = 1'b1;
    tick();
    chk("load_state",  int'(bus.state), 5);
    chk("load_mem_en", int'(bus.mem_en), 1);
    chk("load_fr_en",  int'(bus.fr_en), 0);
    bus.sk_strobe  = 1'b0;
    bus.simon_says = 1'b1;
    tick();
    chk("play_state",   int'(bus.state), 1);
    chk("play_sd_srst", int'(bus.sd_srst), 0);
    chk("play_mem_en",  int'(bus.mem_en), 0);

    // Combo held at PLAY cycle 20 -> PASS, hold 100 cycles, release at 40
    repeat (19) tick();
    bus.combo_held = 1'b1;
    bus.any_held   = 1'b1;
    tick();
    chk("pass_state", int'(bus.state), 3);
    chk("pass_score", int'(bus.score), 1);
    chk("pass_is_correct", int'(bus.is_correct), 1);
    bus.combo_held = 1'b0;
    n = 0;
    while (int'(bus.state) == PASS && n < 300) begin
      n++;
      if (n == 40) bus.any_held = 1'b0;
      tick();
    end
    chk("pass_dwell", n, 100);
    chk("pass_exit", int'(bus.state), 5);
    tick();
    chk("pass_replay", int'(bus.state), 1);

    // Strobe while simon_says=0 -> FAIL, score kept
    bus.simon_says = 1'b0;
    bus.sk_strobe  = 1'b1;
    tick();
    bus.sk_strobe = 1'b0;
    chk("fail_state", int'(bus.state), 2);
    chk("fail_is_wrong", int'(bus.is_wrong), 1);
    n = 0;
    while (int'(bus.state) == FAIL && n < 300) begin
      n++;
      tick();
    end
    chk("fail_dwell", n, 100);
    chk("fail_exit", int'(bus.state), LIVES_ON ? 5 : 0);
    chk("fail_score", int'(bus.score), 1);

    // Combo and timeout together -> PASS; timeout alone -> FAIL
    go_play();
    bus.simon_says  = 1'b1;
    bus.combo_held  = 1'b1;
    bus.sd_is_empty = 1'b1;
    tick();
    chk("combo_empty_pass", int'(bus.state), 3);
    wait_leave(PASS);
    go_play();
    bus.simon_says  = 1'b1;
    bus.sd_is_empty = 1'b1;
    tick();
    chk("empty_fail", int'(bus.state), 2);
    wait_leave(FAIL);

    // Async reset mid-PLAY with a PASS pending: no score update
    go_play();
    bus.simon_says = 1'b1;
    bus.combo_held = 1'b1;
    tick();
    wait_leave(PASS);
    go_play();
    bus.simon_says  = 1'b0;
    bus.sd_is_empty = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(bus.state), 0);
    chk("arst_score", int'(bus.score), 0);
    chk("arst_sd_srst", int'(bus.sd_srst), 1);
    tick();
    bus.sd_is_empty = 1'b0;
    rst_n = 1'b1;
    tick();

    // Nine passes -> WIN
    for (int i = 0; i < 9; i++) begin
      go_play();
      bus.simon_says = 1'b1;
      bus.combo_held = 1'b1;
      tick();
      wait_leave(PASS);
    end
    chk("win_state", int'(bus.state), 4);
    chk("win_score", int'(bus.score), 9);
    bus.sk_strobe = 1'b1;
    tick();
    chk("win_to_ready", int'(bus.state), 0);
    chk("ready_score_kept", int'(bus.score), 9);
    tick();
    bus.sk_strobe = 1'b0;
    chk("restart_state", int'(bus.state), 5);
    chk("restart_score", int'(bus.score), 0);

    // Randomised play against the model
    for (int i = 0; i < 6000; i++) begin
      bus.sk_strobe   = ($urandom_range(7) == 0);
      bus.simon_says  = $urandom_range(1) == 1;
      bus.combo_held  = ($urandom_range(29) == 0);
      bus.stray_press = ($urandom_range(39) == 0);
      bus.any_held    = ($urandom_range(3) == 0);
      bus.sd_is_empty = ($urandom_range(39) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
